// File: rtl/exp_series_unit.sv
// Fixed-point e^x / e^-x engine for x in [0,1), built by summing Taylor terms
// one at a time: each term costs a multiply by x and a multiply by 1/k.
module exp_series_unit #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 2,
    parameter int TERMS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              neg,
    input  logic [FRAC_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic [INT_W-1:0]  intpart,
    output logic [FRAC_W-1:0] fracpart
);

    // e^x < 3 for x < 1, so the accumulator keeps at least two integer bits
    // plus sign; a narrow INT_W then saturates instead of wrapping.
    localparam int SUM_W = (INT_W + FRAC_W + 1 > FRAC_W + 3) ? INT_W + FRAC_W + 1 : FRAC_W + 3;
    localparam int OUT_W = INT_W + FRAC_W;
    localparam int K_W   = 5;
    localparam int R_N   = 1 << K_W;

    localparam logic signed [SUM_W-1:0] ONE_SUM = SUM_W'(64'd1 << FRAC_W);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, MULX, MULR, DONE} state_t;

    state_t                   state, state_next;
    logic [FRAC_W-1:0]        xr;
    logic                     nr;
    logic [FRAC_W:0]          term;
    logic [FRAC_W:0]          p;
    logic signed [SUM_W-1:0]  sum;
    logic [K_W-1:0]           k;

    logic [FRAC_W:0]          recip [R_N];
    logic [2*FRAC_W+1:0]      prod_x;
    logic [2*FRAC_W+1:0]      prod_r;
    logic [FRAC_W:0]          p_next;
    logic [FRAC_W:0]          t;
    logic signed [SUM_W-1:0]  t_ext;
    logic signed [SUM_W-1:0]  sum_next;
    logic [OUT_W-1:0]         sum_clamped;
    logic                     last;

    // Reciprocal table 2^FRAC_W / k; entries 0 and 1 are both exactly one.
    genvar gi;
    generate
        for (gi = 0; gi < R_N; gi++) begin : g_recip
            if (gi < 2) begin : g_one
                assign recip[gi] = (FRAC_W+1)'(64'd1 << FRAC_W);
            end else begin : g_div
                assign recip[gi] = (FRAC_W+1)'((64'd1 << FRAC_W) / gi);
            end
        end
    endgenerate

    always_comb begin
        prod_x   = term * {1'b0, xr};
        p_next   = (FRAC_W+1)'(prod_x >> FRAC_W);
        prod_r   = p * recip[k];
        t        = (FRAC_W+1)'(prod_r >> FRAC_W);
        t_ext    = $signed({{(SUM_W-FRAC_W-1){1'b0}}, t});
        sum_next = (nr && k[0]) ? sum - t_ext : sum + t_ext;
        if (sum_next < 0)
            sum_clamped = '0;
        else if (sum_next > SAT_MAX)
            sum_clamped = '1;
        else
            sum_clamped = OUT_W'(sum_next);
        last = (t == '0) || (k == K_W'(TERMS));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = MULX;
            MULX: state_next = MULR;
            MULR: state_next = last ? DONE : MULX;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            xr       <= '0;
            nr       <= 1'b0;
            term     <= '0;
            p        <= '0;
            sum      <= '0;
            k        <= '0;
            intpart  <= '0;
            fracpart <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr   <= x;
                        nr   <= neg;
                        term <= (FRAC_W+1)'(64'd1 << FRAC_W);
                        sum  <= ONE_SUM;
                        k    <= K_W'(1);
                    end
                end
                MULX: p <= p_next;
                MULR: begin
                    term <= t;
                    sum  <= sum_next;
                    k    <= k + K_W'(1);
                    if (last) begin
                        intpart  <= sum_clamped[OUT_W-1:FRAC_W];
                        fracpart <= sum_clamped[FRAC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_unit.sv
// Randomised and directed bench for exp_series_unit: a default instance and a
// 1-bit-integer instance share stimulus; a negedge monitor scores every done.
module tb_exp_series_unit;
    localparam int F  = 16;
    localparam int TN = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          neg = 1'b0;
    logic [F-1:0]  x = '0;
    logic          busy, done, busy1, done1;
    logic [1:0]    intpart;
    logic [F-1:0]  fracpart;
    logic [0:0]    intpart1;
    logic [F-1:0]  fracpart1;

    exp_series_unit #(.FRAC_W(F), .INT_W(2), .TERMS(TN)) dut (
        .clk(clk), .rst(rst), .start(start), .neg(neg), .x(x),
        .busy(busy), .done(done), .intpart(intpart), .fracpart(fracpart)
    );

    exp_series_unit #(.FRAC_W(F), .INT_W(1), .TERMS(TN)) dut1 (
        .clk(clk), .rst(rst), .start(start), .neg(neg), .x(x),
        .busy(busy1), .done(done1), .intpart(intpart1), .fracpart(fracpart1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint ip;
        longint fp;
        int     lat;
        int     t0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Taylor sum with the truncation rules applied term by term in wide integers.
    function automatic void model(input longint xv, input bit ng, input int intw,
                                  output longint ip, output longint fp, output int n);
        longint term, sum, p, r, t, mx;
        term = 64'd1 << F;
        sum  = 64'd1 << F;
        n = 0;
        for (int kk = 1; kk <= TN; kk++) begin
            p = (term * xv) >>> F;
            r = (kk == 1) ? (64'd1 << F) : ((64'd1 << F) / kk);
            t = (p * r) >>> F;
            term = t;
            if (ng && (kk % 2 == 1)) sum = sum - t;
            else sum = sum + t;
            n = kk;
            if (t == 0) break;
        end
        mx = (64'd1 << (intw + F)) - 1;
        if (sum < 0) sum = 0;
        if (sum > mx) sum = mx;
        ip = sum >>> F;
        fp = sum & 64'hFFFF;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    $display("txn w2: int=%0d frac=%04h lat=%0d", intpart, fracpart, cyc - e.t0);
                    check("w2_int", intpart, e.ip);
                    check("w2_frac", fracpart, e.fp);
                    check("w2_latency", cyc - e.t0, e.lat);
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done1: got done=1 expected no pending result");
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    $display("txn w1: int=%0d frac=%04h lat=%0d", intpart1, fracpart1, cyc - e.t0);
                    check("w1_int", intpart1, e.ip);
                    check("w1_frac", fracpart1, e.fp);
                    check("w1_latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic run_op(input logic [F-1:0] xv, input bit ng, input bit inject,
                          output longint ip, output longint fp, output longint ip1, output longint fp1);
        exp_t e;
        int n;
        int cnt;
        @(negedge clk);
        x = xv; neg = ng; start = 1'b1;
        model(xv, ng, 2, e.ip, e.fp, n);
        e.t0 = cyc + 1; e.lat = 2 * n;
        q0.push_back(e);
        model(xv, ng, 1, e.ip, e.fp, n);
        q1.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (inject && cnt == 2) begin
                start = 1'b1; x = F'($urandom); neg = ~ng;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (cnt >= 100) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        ip = intpart; fp = fracpart; ip1 = intpart1; fp1 = fracpart1;
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("done_single", done, 0);
        @(negedge clk);
    endtask

    longint ip, fp, ip1, fp1, diff;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_int", intpart, 0);
        check("rst_frac", fracpart, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(16'h0000, 1'b0, 1'b0, ip, fp, ip1, fp1);
        check("x0_int", ip, 1);
        check("x0_frac", fp, 0);

        run_op(16'h000A, 1'b0, 1'b0, ip, fp, ip1, fp1);
        check("x10_int", ip, 1);
        check("x10_frac", fp, 16'h000A);

        run_op(16'h8000, 1'b0, 1'b0, ip, fp, ip1, fp1);
        check("ehalf_int", ip, 1);
        diff = fp - 16'hA612;
        check("ehalf_tol", (diff <= 8 && diff >= -8) ? 1 : 0, 1);

        run_op(16'hFFFF, 1'b1, 1'b1, ip, fp, ip1, fp1);
        check("einv_int", ip, 0);
        diff = fp - 16'h5E2D;
        check("einv_tol", (diff <= 8 && diff >= -8) ? 1 : 0, 1);

        run_op(16'hFFFF, 1'b0, 1'b0, ip, fp, ip1, fp1);
        check("sat_int", ip1, 1);
        check("sat_frac", fp1, 16'hFFFF);
        check("e1_int", ip, 2);

        // Abort mid-run: outputs from the previous result must clear at once.
        @(negedge clk);
        x = 16'h8000; neg = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_int", intpart, 0);
        check("abort_frac", fracpart, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", busy, 0);

        run_op(16'h0000, 1'b0, 1'b0, ip, fp, ip1, fp1);
        check("post_rst_int", ip, 1);
        check("post_rst_frac", fp, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(F'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0, ip, fp, ip1, fp1);
        end

        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
